encoder_8b10b: RTL

ENCODER_8B10B -- requirements
Module: encoder_8b10b

---
 rtl/encoder_8b10b_pkg.sv | 25 ++
 rtl/encoder_8b10b_if.sv | 12 +
 rtl/enc_subblock.sv | 36 +++
 rtl/encoder_8b10b.sv | 37 +++
 4 files changed

// File: rtl/encoder_8b10b_pkg.sv
// encoder_8b10b_pkg: shared constants, code tables and K legality for the 8b/10b encoder
package encoder_8b10b_pkg;
  typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_t;
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [5:0] K28_6B = 6'b001111;
  localparam logic [5:0] D6B [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4B [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] A7_4B = 4'b0111;
  localparam logic [3:0] K4B [8] = '{
    4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [7:0] LEGAL_K [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  function automatic logic is_legal_k(input logic [7:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) hit |= (d == LEGAL_K[i]);
    return hit;
  endfunction
endpackage

// File: rtl/encoder_8b10b_if.sv
// encoder_8b10b_if: byte-in / symbol-out bundle of the 8b/10b encoder
interface encoder_8b10b_if;
  import encoder_8b10b_pkg::*;
  logic [7:0] TxParallel_8;
  logic TxDataK;
  logic TxValid;
  logic [9:0] TxParallel_10;
  rd_t RD;
  logic Code_Error;
  modport master (output TxParallel_8, TxDataK, TxValid, input TxParallel_10, RD, Code_Error);
  modport slave (input TxParallel_8, TxDataK, TxValid, output TxParallel_10, RD, Code_Error);
endinterface

// File: rtl/enc_subblock.sv
// enc_subblock: one 5b/6b (W=6) or 3b/4b (W=4) sub-block encode with disparity tracking
module enc_subblock
  import encoder_8b10b_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [7:0]   data,
  input  logic         k,
  input  rd_t          rd_in,
  output logic [W-1:0] code,
  output rd_t          rd_out
);
  localparam logic [W-1:0] HI_HALF = {{(W/2){1'b1}}, {(W/2){1'b0}}};
  logic [W-1:0] base;
  logic flip;
  if (W == 6) begin : g_6b
    logic unused_hgf;
    assign unused_hgf = ^data[7:5];
    assign base = (k && data[4:0] == 5'd28) ? K28_6B : D6B[data[4:0]];
  end else begin : g_4b
    logic a7;
    assign a7 = !k && data[7:5] == 3'd7 &&
                (rd_in == RD_POS ? data[4:0] inside {5'd11, 5'd13, 5'd14}
                                 : data[4:0] inside {5'd17, 5'd18, 5'd20});
    assign base = k ? K4B[data[7:5]] : a7 ? A7_4B : D4B[data[7:5]];
  end
  // Tables hold the RD- form; RD+ inverts unbalanced codes, the biased neutral code and all K rows
  always_comb begin
    flip = k || $countones(base) != W/2 || base == HI_HALF;
    code = (rd_in == RD_POS && flip) ? ~base : base;
    rd_out = $countones(code) > W/2 ? RD_POS :
             $countones(code) < W/2 ? RD_NEG :
             code == ~HI_HALF ? RD_POS :
             code == HI_HALF ? RD_NEG : rd_in;
  end
endmodule

// File: rtl/encoder_8b10b.sv
// encoder_8b10b: registered 8b/10b encoder with comma on idle and illegal-K substitution
module encoder_8b10b
  import encoder_8b10b_pkg::*;
(
  input logic BitCLK_10,
  input logic Reset,
  encoder_8b10b_if.slave bus
);
  logic [5:0] c6;
  logic [3:0] c4;
  rd_t rd_6b, rd_4b, rd_q;
  logic [9:0] sym_q;
  logic err_q, err, comma;
  enc_subblock #(.W(6)) u_6b (
    .data(bus.TxParallel_8), .k(bus.TxDataK), .rd_in(rd_q), .code(c6), .rd_out(rd_6b)
  );
  enc_subblock #(.W(4)) u_4b (
    .data(bus.TxParallel_8), .k(bus.TxDataK), .rd_in(rd_6b), .code(c4), .rd_out(rd_4b)
  );
  assign err = bus.TxValid && bus.TxDataK && !is_legal_k(bus.TxParallel_8);
  assign comma = !bus.TxValid || err;
  // Symbol, running disparity and error flag advance together, one symbol per edge
  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      sym_q <= K28_5_RDN;
      rd_q <= RD_NEG;
      err_q <= 1'b0;
    end else begin
      sym_q <= comma ? (rd_q == RD_POS ? K28_5_RDP : K28_5_RDN) : {c6, c4};
      rd_q <= comma ? rd_t'(~rd_q) : rd_4b;
      err_q <= err;
    end
  end
  assign bus.TxParallel_10 = sym_q;
  assign bus.RD = rd_q;
  assign bus.Code_Error = err_q;
endmodule
